// File: rtl/sensor_packet_scheduler.sv
// Merges quat/gyro samples into tear-free snapshots committed only while cs_n is idle.
// Optional macro PKT_SEQ_EN adds a 6-bit packet sequence number in snap_flags[7:2].
module sensor_packet_scheduler #(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        quat_valid,
    input  logic [15:0] quat_w,
    input  logic [15:0] quat_x,
    input  logic [15:0] quat_y,
    input  logic [15:0] quat_z,
    input  logic        gyro_valid,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic        cs_n,
    output logic [15:0] snap_quat_w,
    output logic [15:0] snap_quat_x,
    output logic [15:0] snap_quat_y,
    output logic [15:0] snap_quat_z,
    output logic [15:0] snap_gyro_x,
    output logic [15:0] snap_gyro_y,
    output logic [15:0] snap_gyro_z,
    output logic [7:0]  snap_flags,
    output logic        drdy,
    output logic [7:0]  overrun_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timer_inc;
    logic          commit;

    logic          s1;
    logic          s2;
    logic          cs_idle;
    logic          cs_fall;

    logic [15:0]   stg_w, stg_x, stg_y, stg_z;
    logic [15:0]   stg_gx, stg_gy, stg_gz;
    logic          quat_fresh;
    logic          gyro_fresh;
    logic          any_pulse;
    logic          ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= cs_n;
            s2 <= s1;
        end
    end

    // Raw cs_n term blocks commit even for glitches the synchronizer misses
    assign cs_idle   = cs_n & s1 & s2;
    assign cs_fall   = s2 & ~s1;
    assign any_pulse = quat_valid | gyro_valid;
    assign ready     = (quat_fresh & gyro_fresh) | (timer == T_LAST);

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_pulse) begin
                    state_next = COLLECT;
                    timer_clr  = 1'b1;
                end
            end
            COLLECT: begin
                if (ready) begin
                    if (cs_idle) commit = 1'b1;
                    else         state_next = WAIT_CS;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            WAIT_CS: begin
                if (cs_idle) commit = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // A pulse landing on the commit edge starts the next packet
        if (commit) begin
            state_next = any_pulse ? COLLECT : IDLE;
            timer_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_w      <= '0;
            stg_x      <= '0;
            stg_y      <= '0;
            stg_z      <= '0;
            stg_gx     <= '0;
            stg_gy     <= '0;
            stg_gz     <= '0;
            quat_fresh <= 1'b0;
            gyro_fresh <= 1'b0;
        end else begin
            if (quat_valid) begin
                stg_w <= quat_w;
                stg_x <= quat_x;
                stg_y <= quat_y;
                stg_z <= quat_z;
            end
            if (gyro_valid) begin
                stg_gx <= gyro_x;
                stg_gy <= gyro_y;
                stg_gz <= gyro_z;
            end
            if (commit) begin
                quat_fresh <= quat_valid;
                gyro_fresh <= gyro_valid;
            end else begin
                quat_fresh <= quat_fresh | quat_valid;
                gyro_fresh <= gyro_fresh | gyro_valid;
            end
        end
    end

`ifdef PKT_SEQ_EN
    logic [5:0] seq;
    logic [5:0] seq_next;

    assign seq_next = seq + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      seq <= '0;
        else if (commit) seq <= seq_next;
    end
`else
    logic [5:0] seq_next;

    assign seq_next = 6'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_quat_w <= '0;
            snap_quat_x <= '0;
            snap_quat_y <= '0;
            snap_quat_z <= '0;
            snap_gyro_x <= '0;
            snap_gyro_y <= '0;
            snap_gyro_z <= '0;
            snap_flags  <= '0;
        end else if (commit) begin
            snap_quat_w <= stg_w;
            snap_quat_x <= stg_x;
            snap_quat_y <= stg_y;
            snap_quat_z <= stg_z;
            snap_gyro_x <= stg_gx;
            snap_gyro_y <= stg_gy;
            snap_gyro_z <= stg_gz;
            snap_flags  <= {seq_next, gyro_fresh, quat_fresh};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drdy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (commit)       drdy <= 1'b1;
            else if (cs_fall) drdy <= 1'b0;
            if (commit && drdy && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_sensor_packet_scheduler.sv
// Scoreboard bench for sensor_packet_scheduler with TIMEOUT_CYCLES=8.
// Honours PKT_SEQ_EN the same way as the design.
module tb_sensor_packet_scheduler;

    localparam int TO = 8;

    typedef logic [128:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        quat_valid;
    logic [15:0] quat_w, quat_x, quat_y, quat_z;
    logic        gyro_valid;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        cs_n;
    logic [15:0] snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z;
    logic [15:0] snap_gyro_x, snap_gyro_y, snap_gyro_z;
    logic [7:0]  snap_flags;
    logic        drdy;
    logic [7:0]  overrun_cnt;

    sensor_packet_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .quat_valid  (quat_valid),
        .quat_w      (quat_w),
        .quat_x      (quat_x),
        .quat_y      (quat_y),
        .quat_z      (quat_z),
        .gyro_valid  (gyro_valid),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .cs_n        (cs_n),
        .snap_quat_w (snap_quat_w),
        .snap_quat_x (snap_quat_x),
        .snap_quat_y (snap_quat_y),
        .snap_quat_z (snap_quat_z),
        .snap_gyro_x (snap_gyro_x),
        .snap_gyro_y (snap_gyro_y),
        .snap_gyro_z (snap_gyro_z),
        .snap_flags  (snap_flags),
        .drdy        (drdy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    pkt_t sb[$];
    pkt_t last_pkt;

    logic [15:0] sq [4];
    logic [15:0] sg [3];
    logic        fq, fg, m_drdy, rise_exp;
    logic [7:0]  m_ovr;
    logic [5:0]  m_seq;

    task automatic check(input string tag, input pkt_t got, input pkt_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic pkt_t pack_dut();
        return {snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z,
                snap_gyro_x, snap_gyro_y, snap_gyro_z,
                snap_flags, overrun_cnt, drdy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) sq[i] = '0;
        for (int i = 0; i < 3; i++) sg[i] = '0;
        fq = 0; fg = 0; m_drdy = 0; rise_exp = 0;
        m_ovr = '0; m_seq = '0;
        last_pkt = '0;
        sb.delete();
    endtask

    task automatic drive(input bit dq, input bit dg,
                         input logic [63:0] qd, input logic [47:0] gd);
        quat_valid = dq;
        gyro_valid = dg;
        if (dq) begin
            {quat_w, quat_x, quat_y, quat_z} = qd;
            sq[0] = qd[63:48]; sq[1] = qd[47:32];
            sq[2] = qd[31:16]; sq[3] = qd[15:0];
            fq = 1;
        end
        if (dg) begin
            {gyro_x, gyro_y, gyro_z} = gd;
            sg[0] = gd[47:32]; sg[1] = gd[31:16]; sg[2] = gd[15:0];
            fg = 1;
        end
        @(negedge clk);
        quat_valid = 0;
        gyro_valid = 0;
    endtask

    task automatic expect_commit();
        pkt_t p;
        rise_exp = !m_drdy;
        if (m_drdy && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
`ifdef PKT_SEQ_EN
        m_seq = m_seq + 6'd1;
`endif
        p = {sq[0], sq[1], sq[2], sq[3], sg[0], sg[1], sg[2],
             m_seq, fg, fq, m_ovr, 1'b1};
        fq = 0; fg = 0; m_drdy = 1;
        sb.push_back(p);
    endtask

    task automatic wait_commit(input int lat);
        int   n = 0;
        pkt_t e;
        if (rise_exp) begin
            while (drdy !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("latency", pkt_t'(n), pkt_t'(lat));
        end else begin
            repeat (lat) @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no entry want one");
        end else begin
            e = sb.pop_front();
            last_pkt = e;
            check("packet", pack_dut(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        pkt_t cur;
        int   n;
        model_reset();
        rst_n = 0;
        cs_n = 1;
        quat_valid = 0; gyro_valid = 0;
        quat_w = '0; quat_x = '0; quat_y = '0; quat_z = '0;
        gyro_x = '0; gyro_y = '0; gyro_z = '0;

        // reset with random activity
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            quat_valid = 1'($urandom);
            gyro_valid = 1'($urandom);
            cs_n = 1'($urandom);
            {quat_w, quat_x} = 32'($urandom);
            {gyro_x, gyro_z} = 32'($urandom);
            @(negedge clk);
            check("reset_hold", pack_dut(), '0);
        end
        quat_valid = 0; gyro_valid = 0; cs_n = 1;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("reset_release", pack_dut(), '0);

        // both pulses, gyro 3 cycles after quat
        drive(1, 0, {16'h1234, 16'h0001, 16'hFFFF, 16'h8000}, '0);
        repeat (2) @(negedge clk);
        drive(0, 1, '0, {16'h0102, 16'h0304, 16'h0506});
        expect_commit();
        wait_commit(1);

        // quat only -> timeout commit
        drive(1, 0, {16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0}, '0);
        expect_commit();
        wait_commit(TO);

        // chip select holds off commit
        cs_n = 0;
        m_drdy = 0;
        n = 0;
        while (drdy !== 1'b0 && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("drdy_clear", pkt_t'(drdy), '0);
        drive(1, 0, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, '0);
        drive(0, 1, '0, {16'h5555, 16'h6666, 16'h7777});
        repeat (12) @(negedge clk);
        cur = pack_dut();
        check("cs_low_hold", cur, {last_pkt[128:1], 1'b0});
        expect_commit();
        cs_n = 1;
        wait_commit(3);

        // pulse on the commit edge goes to staging only
        drive(1, 1, {$urandom, $urandom}, 48'({$urandom, $urandom}));
        expect_commit();
        drive(1, 0, {16'hCAFE, 16'hBEEF, 16'h0000, 16'h7FFF}, '0);
        wait_commit(0);
        expect_commit();
        wait_commit(TO);

        // unread commits saturate the overrun count; sequence wraps
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, {$urandom, $urandom}, 48'({$urandom, $urandom}));
            expect_commit();
            wait_commit(1);
        end
        check("ovr_sat", pkt_t'(overrun_cnt), pkt_t'(8'hFF));

        // reset mid-collect discards staging
        drive(1, 0, {16'h9999, 16'h8888, 16'h7777, 16'h6666}, '0);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check("async_reset", pack_dut(), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        drive(0, 1, '0, {16'h0A0B, 16'h0C0D, 16'h0E0F});
        expect_commit();
        wait_commit(TO);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
